// File: rtl/cluster_monitor_pkg.sv
`default_nettype none
// ---- cluster_monitor_pkg : default widths and FSM encoding for the cluster count monitor ----
// ---- rev 1.0 ----
package cluster_monitor_pkg;

  localparam int CNT_WIDTH_DEF  = 11;
  localparam int WIN_WIDTH_DEF  = 24;
  localparam int SUM_WIDTH_DEF  = 32;
  localparam int OVF_WIDTH_DEF  = 16;
  localparam int NWIN_WIDTH_DEF = 16;

  localparam int ST_W = 1;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cluster_count_monitor_if.sv
`default_nettype none
// ---- cluster_count_monitor_if : per-BX inputs, control and published window results ----
// ---- rev 1.0 ----
interface cluster_count_monitor_if
  import cluster_monitor_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int WIN_WIDTH  = WIN_WIDTH_DEF,
  parameter int SUM_WIDTH  = SUM_WIDTH_DEF,
  parameter int OVF_WIDTH  = OVF_WIDTH_DEF,
  parameter int NWIN_WIDTH = NWIN_WIDTH_DEF
);

  logic [CNT_WIDTH-1:0]  cnt_i;
  logic                  overflow_i;
  logic                  enable_i;
  logic [WIN_WIDTH-1:0]  window_len_i;

  logic [SUM_WIDTH-1:0]  sum_o;
  logic [CNT_WIDTH-1:0]  peak_o;
  logic [OVF_WIDTH-1:0]  ovf_bx_o;
  logic                  sum_sat_o;
  logic [NWIN_WIDTH-1:0] nwin_o;
  logic                  valid_o;
  logic                  busy_o;

  modport master (
    output cnt_i, overflow_i, enable_i, window_len_i,
    input  sum_o, peak_o, ovf_bx_o, sum_sat_o, nwin_o, valid_o, busy_o
  );

  modport slave (
    input  cnt_i, overflow_i, enable_i, window_len_i,
    output sum_o, peak_o, ovf_bx_o, sum_sat_o, nwin_o, valid_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/sat_accum.sv
`default_nettype none
// ---- sat_accum : clearable saturating accumulator; value/sat show the total including this cycle's add ----
// ---- rev 1.0 ----
module sat_accum #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 11
) (
  input  wire                 clock,
  input  wire                 reset,
  input  wire                 clear,
  input  wire                 add_en,
  input  wire  [IN_WIDTH-1:0] addend,
  output logic [WIDTH-1:0]    value,
  output logic                sat
);

  logic [WIDTH-1:0] r_acc;
  logic             r_sat;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sum;

  // One spare bit catches the carry; a clamped accumulator carries again on any non-zero add.
  always_comb begin
    w_add = '0;
    if (add_en) begin
      w_add[IN_WIDTH-1:0] = addend;
    end
    w_sum = {1'b0, r_acc} + w_add;
    value = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    sat   = r_sat | w_sum[WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= value;
      r_sat <= sat;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cluster_count_monitor.sv
`default_nettype none
// ---- cluster_count_monitor : back-to-back N-BX windows of cluster sum, peak and overflow-BX count ----
// ---- rev 1.0 ----
module cluster_count_monitor
  import cluster_monitor_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int WIN_WIDTH  = WIN_WIDTH_DEF,
  parameter int SUM_WIDTH  = SUM_WIDTH_DEF,
  parameter int OVF_WIDTH  = OVF_WIDTH_DEF,
  parameter int NWIN_WIDTH = NWIN_WIDTH_DEF
) (
  input wire                     clock,
  input wire                     reset,
  cluster_count_monitor_if.slave mon
);

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_ovf;
  logic [WIN_WIDTH-1:0]  r_len;
  logic [WIN_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_peak;
  logic [CNT_WIDTH-1:0]  w_peak_nxt;

  logic [SUM_WIDTH-1:0]  r_sum;
  logic                  r_sum_sat;
  logic [OVF_WIDTH-1:0]  r_ovf_bx;
  logic [CNT_WIDTH-1:0]  r_peak_res;
  logic [NWIN_WIDTH-1:0] r_nwin;
  logic                  r_valid;

  logic                  w_busy;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_close;
  logic                  w_accum;
  logic                  w_clear;

  logic [SUM_WIDTH-1:0]  w_sum_val;
  logic                  w_sum_sat;
  logic [OVF_WIDTH-1:0]  w_ovf_val;
  logic                  w_ovf_sat_unused;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= mon.cnt_i;
      r_ovf <= mon.overflow_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mon.enable_i && (mon.window_len_i != '0)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!mon.enable_i) begin
          w_state_nxt = ST_IDLE;
        end else if ((r_count == r_len) && (mon.window_len_i == '0)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_count = samples captured so far; the window closes once all N sit in the pipe.
  always_comb begin
    w_busy  = 1'b0;
    w_start = 1'b0;
    w_abort = 1'b0;
    w_close = 1'b0;
    w_accum = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start = mon.enable_i && (mon.window_len_i != '0);
      end
      ST_RUN: begin
        w_busy  = 1'b1;
        w_abort = !mon.enable_i;
        w_accum = mon.enable_i && (r_count != '0);
        w_close = mon.enable_i && (r_count == r_len);
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign w_clear    = w_start | w_abort | w_close;
  assign w_peak_nxt = (w_accum && (r_cnt > r_peak)) ? r_cnt : r_peak;

  sat_accum #(
    .WIDTH    (SUM_WIDTH),
    .IN_WIDTH (CNT_WIDTH)
  ) u_sum_accum (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_clear),
    .add_en (w_accum),
    .addend (r_cnt),
    .value  (w_sum_val),
    .sat    (w_sum_sat)
  );

  sat_accum #(
    .WIDTH    (OVF_WIDTH),
    .IN_WIDTH (1)
  ) u_ovf_accum (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_clear),
    .add_en (w_accum),
    .addend (r_ovf),
    .value  (w_ovf_val),
    .sat    (w_ovf_sat_unused)
  );

  // The sample captured on a close edge is already the first of the next window.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_len      <= '0;
      r_count    <= '0;
      r_peak     <= '0;
      r_sum      <= '0;
      r_sum_sat  <= 1'b0;
      r_ovf_bx   <= '0;
      r_peak_res <= '0;
      r_nwin     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_close;
      if (w_start || w_abort) begin
        r_count <= '0;
        r_peak  <= '0;
        if (w_start) begin
          r_len <= mon.window_len_i;
        end
      end else if (w_close) begin
        r_sum      <= w_sum_val;
        r_sum_sat  <= w_sum_sat;
        r_ovf_bx   <= w_ovf_val;
        r_peak_res <= w_peak_nxt;
        r_nwin     <= r_nwin + NWIN_WIDTH'(1);
        r_len      <= mon.window_len_i;
        r_count    <= WIN_WIDTH'(1);
        r_peak     <= '0;
      end else if (w_busy) begin
        r_count <= r_count + WIN_WIDTH'(1);
        r_peak  <= w_peak_nxt;
      end
    end
  end

  assign mon.sum_o     = r_sum;
  assign mon.peak_o    = r_peak_res;
  assign mon.ovf_bx_o  = r_ovf_bx;
  assign mon.sum_sat_o = r_sum_sat;
  assign mon.nwin_o    = r_nwin;
  assign mon.valid_o   = r_valid;
  assign mon.busy_o    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_cluster_count_monitor.sv
`default_nettype none
// ---- tb_cluster_count_monitor : default-width and narrow-width monitors against a window-queue model ----
// ---- rev 1.0 ----
module tb_cluster_count_monitor;

  localparam int CW   = 11;
  localparam int WW   = 24;
  localparam int SW_A = 32;
  localparam int OW_A = 16;
  localparam int NW_A = 16;
  localparam int SW_B = 12;
  localparam int OW_B = 3;
  localparam int NW_B = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] cnt   = '0;
  logic          ovf   = 1'b0;
  logic          en    = 1'b0;
  logic [WW-1:0] len   = '0;

  always #5 clock = ~clock;

  cluster_count_monitor_if #(.CNT_WIDTH(CW), .WIN_WIDTH(WW), .SUM_WIDTH(SW_A),
                             .OVF_WIDTH(OW_A), .NWIN_WIDTH(NW_A)) bus_a ();
  cluster_count_monitor_if #(.CNT_WIDTH(CW), .WIN_WIDTH(WW), .SUM_WIDTH(SW_B),
                             .OVF_WIDTH(OW_B), .NWIN_WIDTH(NW_B)) bus_b ();

  assign bus_a.cnt_i        = cnt;
  assign bus_a.overflow_i   = ovf;
  assign bus_a.enable_i     = en;
  assign bus_a.window_len_i = len;
  assign bus_b.cnt_i        = cnt;
  assign bus_b.overflow_i   = ovf;
  assign bus_b.enable_i     = en;
  assign bus_b.window_len_i = len;

  cluster_count_monitor #(.CNT_WIDTH(CW), .WIN_WIDTH(WW), .SUM_WIDTH(SW_A),
                          .OVF_WIDTH(OW_A), .NWIN_WIDTH(NW_A)) dut_a (
    .clock (clock),
    .reset (reset),
    .mon   (bus_a)
  );

  cluster_count_monitor #(.CNT_WIDTH(CW), .WIN_WIDTH(WW), .SUM_WIDTH(SW_B),
                          .OVF_WIDTH(OW_B), .NWIN_WIDTH(NW_B)) dut_b (
    .clock (clock),
    .reset (reset),
    .mon   (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the current window is a plain list of samples; results are recomputed from it at close.
  int unsigned q_cnt[$];
  bit          q_ovf[$];
  bit          m_run;
  int unsigned m_n;
  longint      ea_sum, eb_sum;
  longint      e_peak, ea_ovf, eb_ovf, ea_nwin, eb_nwin;
  bit          ea_sat, eb_sat, e_valid, e_busy;

  initial begin
    longint tot;
    longint pk;
    longint oc;
    forever begin
      @(posedge clock);
      if (reset) begin
        q_cnt.delete(); q_ovf.delete();
        m_run = 0; m_n = 0;
        ea_sum = 0; eb_sum = 0; e_peak = 0; ea_ovf = 0; eb_ovf = 0;
        ea_nwin = 0; eb_nwin = 0; ea_sat = 0; eb_sat = 0; e_valid = 0;
      end else begin
        e_valid = 0;
        if (!m_run) begin
          if (en && len != 0) begin
            m_run = 1; m_n = len;
            q_cnt.delete(); q_ovf.delete();
          end
        end else if (!en) begin
          m_run = 0;
          q_cnt.delete(); q_ovf.delete();
        end else begin
          if (q_cnt.size() == m_n) begin
            tot = 0; pk = 0; oc = 0;
            foreach (q_cnt[i]) begin
              tot += q_cnt[i];
              if (q_cnt[i] > pk) pk = q_cnt[i];
              if (q_ovf[i]) oc++;
            end
            ea_sum  = (tot > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : tot;
            ea_sat  = (tot > 64'hFFFF_FFFF);
            eb_sum  = (tot > 4095) ? 4095 : tot;
            eb_sat  = (tot > 4095);
            ea_ovf  = (oc > 65535) ? 65535 : oc;
            eb_ovf  = (oc > 7) ? 7 : oc;
            ea_nwin = (ea_nwin + 1) % 65536;
            eb_nwin = (eb_nwin + 1) % 8;
            e_peak  = pk;
            e_valid = 1;
            q_cnt.delete(); q_ovf.delete();
            m_n = len;
            if (m_n == 0) m_run = 0;
          end
          if (m_run) begin
            q_cnt.push_back(cnt);
            q_ovf.push_back(ovf);
          end
        end
      end
      e_busy = m_run;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("a_valid", bus_a.valid_o,   e_valid);
      chk("a_busy",  bus_a.busy_o,    e_busy);
      chk("a_sum",   bus_a.sum_o,     ea_sum);
      chk("a_sat",   bus_a.sum_sat_o, ea_sat);
      chk("a_peak",  bus_a.peak_o,    e_peak);
      chk("a_ovf",   bus_a.ovf_bx_o,  ea_ovf);
      chk("a_nwin",  bus_a.nwin_o,    ea_nwin);
      chk("b_valid", bus_b.valid_o,   e_valid);
      chk("b_busy",  bus_b.busy_o,    e_busy);
      chk("b_sum",   bus_b.sum_o,     eb_sum);
      chk("b_sat",   bus_b.sum_sat_o, eb_sat);
      chk("b_peak",  bus_b.peak_o,    e_peak);
      chk("b_ovf",   bus_b.ovf_bx_o,  eb_ovf);
      chk("b_nwin",  bus_b.nwin_o,    eb_nwin);
    end
  end

  initial begin
    int vcnt, first_k, last_k, ovf_tot;
    int t2_cnt[4] = '{10, 20, 5, 7};

    // reset
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_sum", bus_a.sum_o, 0);
    chk("rst_busy", bus_a.busy_o, 0);
    chk("rst_nwin", bus_a.nwin_o, 0);

    // single N=4 window
    en = 1'b1; len = WW'(4); cnt = '0;
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      cnt = CW'(t2_cnt[k]);
      @(negedge clock);
    end
    cnt = '0;
    @(negedge clock);
    chk("t2_valid", bus_a.valid_o, 1);
    chk("t2_sum", bus_a.sum_o, 42);
    chk("t2_peak", bus_a.peak_o, 20);
    chk("t2_ovf", bus_a.ovf_bx_o, 0);
    chk("t2_nwin", bus_a.nwin_o, 1);
    en = 1'b0;
    @(negedge clock);

    // N=3 continuous windows, constant count, two overflow BXs
    en = 1'b1; len = WW'(3); cnt = CW'(1); ovf = 1'b0;
    @(negedge clock);
    vcnt = 0; first_k = 0; last_k = 0; ovf_tot = 0;
    for (int k = 1; k <= 7; k++) begin
      ovf = (k == 2 || k == 5);
      @(negedge clock);
      if (bus_a.valid_o) begin
        vcnt++;
        if (vcnt == 1) first_k = k;
        last_k = k;
        ovf_tot += int'(bus_a.ovf_bx_o);
        chk("t3_sum", bus_a.sum_o, 3);
      end
    end
    chk("t3_strobes", vcnt, 2);
    chk("t3_spacing", last_k - first_k, 3);
    chk("t3_ovf_total", ovf_tot, 2);
    en = 1'b0; ovf = 1'b0;
    @(negedge clock);

    // abort after 5 of 8 samples, then a fresh N=2 window
    en = 1'b1; len = WW'(8);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      cnt = CW'($urandom_range(1, 100));
      @(negedge clock);
    end
    en = 1'b0;
    @(negedge clock);
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (bus_a.valid_o) vcnt++;
    end
    chk("t4_no_valid", vcnt, 0);
    chk("t4_sum_hold", bus_a.sum_o, 3);
    chk("t4_nwin_hold", bus_a.nwin_o, 3);
    en = 1'b1; len = WW'(2); cnt = '0;
    @(negedge clock);
    cnt = CW'(4);
    @(negedge clock);
    cnt = CW'(6);
    @(negedge clock);
    cnt = '0;
    @(negedge clock);
    chk("t4_fresh_valid", bus_a.valid_o, 1);
    chk("t4_fresh_sum", bus_a.sum_o, 10);
    chk("t4_fresh_peak", bus_a.peak_o, 6);
    en = 1'b0;
    @(negedge clock);

    // saturation on the 12-bit sum instance
    en = 1'b1; len = WW'(4);
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      cnt = CW'(1536);
      @(negedge clock);
    end
    cnt = '0;
    @(negedge clock);
    chk("t5_b_sum", bus_b.sum_o, 4095);
    chk("t5_b_sat", bus_b.sum_sat_o, 1);
    chk("t5_b_peak", bus_b.peak_o, 1536);
    chk("t5_a_sum", bus_a.sum_o, 6144);
    chk("t5_a_sat", bus_a.sum_sat_o, 0);
    en = 1'b0;
    @(negedge clock);

    // length change mid-window, then length 0, then N=1
    en = 1'b1; len = WW'(4);
    @(negedge clock);
    len = WW'(2);
    vcnt = 0; first_k = 0; last_k = 0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 7) len = '0;
      cnt = CW'($urandom_range(0, 1536));
      @(negedge clock);
      if (bus_a.valid_o) begin
        vcnt++;
        if (vcnt == 1) first_k = k;
        last_k = k;
      end
    end
    chk("t6_strobes", vcnt, 2);
    chk("t6_first_close", first_k, 5);
    chk("t6_second_close", last_k, 7);
    chk("t6_idle", bus_a.busy_o, 0);
    len = WW'(1);
    @(negedge clock);
    vcnt = 0;
    for (int k = 1; k <= 6; k++) begin
      cnt = CW'($urandom_range(0, 1536));
      @(negedge clock);
      if (bus_a.valid_o) vcnt++;
    end
    chk("t6_n1_strobes", vcnt, 5);
    en = 1'b0;
    @(negedge clock);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 99) < 94);
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 15) == 0) len = '0;
        else len = WW'($urandom_range(1, 9));
      end
      if ($urandom_range(0, 3) == 0) cnt = CW'(1536);
      else cnt = CW'($urandom_range(0, 1536));
      ovf = ($urandom_range(0, 2) != 0);
      @(negedge clock);
    end
    reset = 1'b0;

    // reset in the middle of a running window
    en = 1'b1; len = WW'(5); cnt = CW'(9);
    repeat (4) @(negedge clock);
    reset = 1'b1; en = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("t7_valid", bus_a.valid_o, 0);
      chk("t7_busy", bus_a.busy_o, 0);
      chk("t7_sum", bus_a.sum_o, 0);
      chk("t7_nwin", bus_a.nwin_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
